// File: rtl/alu_pkg.sv
// Shared encodings for the ALU command sequencer: op codes, widths, FSM states
// and the packed command record stored in the command FIFO.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 16;

    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_OR      = 3'b001;
    localparam logic [2:0] OP_XOR     = 3'b010;
    localparam logic [2:0] OP_ADD     = 3'b011;
    localparam logic [2:0] OP_SUB     = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_DIV     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a_div;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous command FIFO; full/empty come from an extra wrap bit on each pointer.
module cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the ALU BEGIN/END handshake: queues commands, issues them one at
// a time with a single-cycle BEGIN, waits for END (or times out) and presents the result.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_x,
    input  logic [DATA_W-1:0] cmd_y,
    input  logic [DATA_W-1:0] cmd_a_div,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [DATA_W-1:0] alu_a_divide,
    output logic [2:0]        alu_op,
    output logic              alu_begin,
    input  logic [OUT_W-1:0]  alu_out,
    input  logic              alu_end,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic [2:0]        res_op,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int FW    = $bits(cmd_t) + TAG_W;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             end_q;
    logic             end_edge;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [FW-1:0]    wdata;
    logic [FW-1:0]    rdata;
    cmd_t             head;
    logic [TAG_W-1:0] head_tag;

    // Gated by resetn so no command is accepted while reset is held.
    assign cmd_ready = resetn & ~full;
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state == S_IDLE) & ~empty;
    assign wdata     = {cmd_op, cmd_a_div, cmd_x, cmd_y, cmd_tag};
    assign {head, head_tag} = rdata;

    assign end_edge  = alu_end & ~end_q;
    assign alu_begin = (state == S_ISSUE);
    assign res_valid = (state == S_HOLD);
    assign res_op    = alu_op;

    cmd_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .wdata  (wdata),
        .rdata  (rdata),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            end_q        <= 1'b0;
            alu_x        <= '0;
            alu_y        <= '0;
            alu_a_divide <= '0;
            alu_op       <= '0;
            res_tag      <= '0;
            res_data     <= '0;
            res_err      <= 1'b0;
        end else begin
            end_q <= alu_end;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        alu_op       <= head.op;
                        alu_x        <= head.x;
                        alu_y        <= head.y;
                        alu_a_divide <= head.a_div;
                        res_tag      <= head_tag;
                        if (head.op == OP_ILLEGAL) begin
                            res_err  <= 1'b1;
                            res_data <= '0;
                            state    <= S_HOLD;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (end_edge) begin
                        res_data <= alu_out;
                        res_err  <= 1'b0;
                        state    <= S_HOLD;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                        state    <= S_HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (res_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU model, result scoreboard, vector table
// plus hand-written sequences for backpressure, illegal op, timeout and mid-op reset.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  a;
        logic [3:0]  tag;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  op;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_x, cmd_y, cmd_a_div;
    logic [3:0]  cmd_tag;
    logic [7:0]  alu_x, alu_y, alu_a_divide;
    logic [2:0]  alu_op;
    logic        alu_begin;
    logic [15:0] alu_out;
    logic        alu_end;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_op;
    logic [3:0]  res_tag;
    logic        res_err;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   begins = 0;
    int   results = 0;
    int   last_begin_cyc = 0;
    int   hs_cyc = 0;
    int   rise_cyc = 0;
    int   alu_lat = 3;
    logic alu_hang = 1'b0;
    exp_t sb[$];
    vec_t vecs[8];

    alu_cmd_sequencer #(
        .DEPTH   (4),
        .TAG_W   (4),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_a_div    (cmd_a_div),
        .cmd_tag      (cmd_tag),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_a_divide (alu_a_divide),
        .alu_op       (alu_op),
        .alu_begin    (alu_begin),
        .alu_out      (alu_out),
        .alu_end      (alu_end),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_op       (res_op),
        .res_tag      (res_tag),
        .res_err      (res_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] x,
                                            input logic [7:0] y, input logic [7:0] a);
        logic [15:0] d;
        logic [15:0] q;
        logic [15:0] r;
        d = {a, x};
        case (op)
            OP_AND: return {8'h00, x & y};
            OP_OR:  return {8'h00, x | y};
            OP_XOR: return {8'h00, x ^ y};
            OP_ADD: return {8'h00, x} + {8'h00, y};
            OP_SUB: return {8'h00, x} - {8'h00, y};
            OP_MUL: return $signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y});
            OP_DIV: begin
                if (y == 8'h00) return 16'hFFFF;
                q = d / {8'h00, y};
                r = d % {8'h00, y};
                return {r[7:0], q[7:0]};
            end
            default: return 16'h0000;
        endcase
    endfunction

    // ALU model: END rises alu_lat cycles after BEGIN and stays high for one cycle.
    initial begin
        logic [15:0] r;
        alu_end = 1'b0;
        alu_out = 16'h0000;
        forever begin
            @(negedge clk);
            if (resetn && alu_begin && !alu_hang) begin
                r = alu_ref(alu_op, alu_x, alu_y, alu_a_divide);
                repeat (alu_lat) @(negedge clk);
                alu_out = r;
                alu_end = 1'b1;
                @(negedge clk);
                alu_end = 1'b0;
            end
        end
    end

    // Monitor: BEGIN pulse width, operand stability while in flight, result scoreboard.
    initial begin
        logic        prev_begin;
        logic        prev_rv;
        logic        in_flight;
        logic        stab_bad;
        logic [26:0] cap;
        exp_t        e;
        prev_begin = 1'b0;
        prev_rv    = 1'b0;
        in_flight  = 1'b0;
        stab_bad   = 1'b0;
        cap        = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_begin = 1'b0;
                prev_rv    = 1'b0;
                in_flight  = 1'b0;
            end else begin
                if (alu_begin) begin
                    begins++;
                    last_begin_cyc = cyc;
                    chk("begin_single_cycle", {31'd0, prev_begin}, 0);
                    in_flight = 1'b1;
                    stab_bad  = 1'b0;
                    cap = {alu_op, alu_x, alu_y, alu_a_divide};
                end else if (in_flight && ({alu_op, alu_x, alu_y, alu_a_divide} !== cap)) begin
                    stab_bad = 1'b1;
                end
                if (res_valid && !prev_rv) rise_cyc = cyc;
                if (res_valid && res_ready) begin
                    results++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got tag 0x%0h data 0x%0h, expected none",
                                 res_tag, res_data);
                    end else begin
                        e = sb.pop_front();
                        chk("res_data", {16'd0, res_data}, {16'd0, e.data});
                        chk("res_op", {29'd0, res_op}, {29'd0, e.op});
                        chk("res_tag", {28'd0, res_tag}, {28'd0, e.tag});
                        chk("res_err", {31'd0, res_err}, {31'd0, e.err});
                        if (e.op != OP_ILLEGAL) chk("operands_stable", {31'd0, stab_bad}, 0);
                    end
                    in_flight = 1'b0;
                end
                prev_begin = alu_begin;
                prev_rv    = res_valid;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] a, input logic [3:0] tag,
                        input logic [15:0] ed, input logic ee);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_a_div = a;
        cmd_tag   = tag;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (cmd_ready) begin
            sb.push_back('{ed, op, tag, ee});
            hs_cyc = cyc;
        end else begin
            checks++;
            failures++;
            $display("FAIL cmd_accept_timeout: got cmd_ready 0, expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        tick(2);
    endtask

    initial begin
        int b0;
        int r0;
        int n;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_a_div = '0;
        cmd_tag   = '0;
        res_ready = 1'b1;

        vecs[0] = '{OP_AND, 8'h11, 8'h05, 8'h00, 4'd3, 16'h0001};
        vecs[1] = '{OP_MUL, 8'hB9, 8'h85, 8'h00, 4'd1, 16'h221D};
        vecs[2] = '{OP_DIV, 8'h8B, 8'h87, 8'h16, 4'd2, 16'h652A};
        vecs[3] = '{OP_OR,  8'hA0, 8'h0C, 8'h5A, 4'd4, 16'h00AC};
        vecs[4] = '{OP_XOR, 8'hFF, 8'h0F, 8'h00, 4'd5, 16'h00F0};
        vecs[5] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'd6, 16'h0100};
        vecs[6] = '{OP_SUB, 8'h05, 8'h07, 8'h00, 4'd7, 16'hFFFE};
        vecs[7] = '{OP_MUL, 8'h7F, 8'h80, 8'h00, 4'd8, 16'hC080};

        #1 resetn = 1'b0;
        #2;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        chk("rst_alu_begin", {31'd0, alu_begin}, 0);
        chk("rst_res_valid", {31'd0, res_valid}, 0);
        chk("rst_res_data", {16'd0, res_data}, 0);
        chk("rst_res_err", {31'd0, res_err}, 0);
        chk("rst_alu_x", {24'd0, alu_x}, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        tick(1);
        chk("ready_after_reset", {31'd0, cmd_ready}, 1);

        for (int i = 0; i < 8; i++) begin
            b0 = begins;
            send(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].a, vecs[i].tag, vecs[i].exp, 1'b0);
            drain(100);
            chk("one_begin_per_cmd", begins - b0, 1);
            if (i == 0) chk("begin_latency", last_begin_cyc - hs_cyc, 2);
        end

        // Backpressure: 4 queued + 1 in flight, result held 10 cycles, then in-order drain.
        res_ready = 1'b0;
        b0 = begins;
        for (int i = 0; i < 5; i++) begin
            send(OP_ADD, 8'(i * 16 + 1), 8'(i + 2), 8'h00, 4'(i),
                 alu_ref(OP_ADD, 8'(i * 16 + 1), 8'(i + 2), 8'h00), 1'b0);
        end
        @(negedge clk);
        chk("ready_low_when_full", {31'd0, cmd_ready}, 0);
        tick(10);
        @(negedge clk);
        chk("held_res_valid", {31'd0, res_valid}, 1);
        chk("held_res_tag", {28'd0, res_tag}, 0);
        chk("held_one_begin", begins - b0, 1);
        tick(1);
        res_ready = 1'b1;
        send(OP_ADD, 8'h51, 8'h07, 8'h00, 4'd5, alu_ref(OP_ADD, 8'h51, 8'h07, 8'h00), 1'b0);
        drain(300);
        chk("six_begins", begins - b0, 6);

        // Illegal op: error result without any BEGIN.
        b0 = begins;
        send(OP_ILLEGAL, 8'h12, 8'h34, 8'h56, 4'd12, 16'h0000, 1'b1);
        drain(50);
        chk("illegal_no_begin", begins - b0, 0);

        // Timeout: TIMEOUT=16 WAIT cycles after BEGIN, error result visible the cycle after.
        alu_hang = 1'b1;
        b0 = begins;
        send(OP_ADD, 8'h01, 8'h02, 8'h00, 4'd13, 16'h0000, 1'b1);
        drain(80);
        chk("timeout_begin", begins - b0, 1);
        chk("timeout_latency", rise_cyc - last_begin_cyc, 17);
        alu_hang = 1'b0;
        send(OP_ADD, 8'h01, 8'h02, 8'h00, 4'd14, 16'h0003, 1'b0);
        drain(50);
        chk("after_timeout_begin", begins - b0, 2);

        // Reset during WAIT with a second command queued; the late END must be ignored.
        alu_lat = 8;
        b0 = begins;
        r0 = results;
        send(OP_MUL, 8'h03, 8'h04, 8'h00, 4'd9, 16'd12, 1'b0);
        send(OP_AND, 8'hF0, 8'h3C, 8'h00, 4'd10, 16'h0030, 1'b0);
        n = 0;
        while (begins == b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_begin_seen", begins - b0, 1);
        tick(2);
        resetn = 1'b0;
        #1;
        chk("midop_alu_begin", {31'd0, alu_begin}, 0);
        chk("midop_res_valid", {31'd0, res_valid}, 0);
        chk("midop_cmd_ready", {31'd0, cmd_ready}, 0);
        chk("midop_alu_x", {24'd0, alu_x}, 0);
        chk("midop_alu_y", {24'd0, alu_y}, 0);
        chk("midop_alu_a_divide", {24'd0, alu_a_divide}, 0);
        chk("midop_alu_op", {29'd0, alu_op}, 0);
        chk("midop_res_data", {16'd0, res_data}, 0);
        chk("midop_res_tag", {28'd0, res_tag}, 0);
        chk("midop_res_op", {29'd0, res_op}, 0);
        chk("midop_res_err", {31'd0, res_err}, 0);
        sb.delete();
        tick(2);
        resetn = 1'b1;
        tick(15);
        chk("flushed_no_begin", begins - b0, 1);
        chk("late_end_no_result", results - r0, 0);
        alu_lat = 3;
        send(OP_XOR, 8'h3C, 8'h0F, 8'h00, 4'd11, 16'h0033, 1'b0);
        drain(50);
        chk("after_reset_begin", begins - b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
